// File: rtl/crc_stream_enc.sv
// crc_stream_enc
//
// Streaming CRC encoder. Data beats pass through a single output register
// (latency 1) while their bits are folded into a CRC. After the beat marked
// i_last goes out, one extra beat carrying the CRC is sent with o_last=1.
// The CRC is MSB-first and non-reflected, with no final XOR. Bit 0 of every
// vector is its MSB and is the first bit processed.
//
// Handshake: a beat moves across an interface on a rising clk edge when
// enable is high and both valid and ready for that interface are high.
// When enable is low, no beat moves on either side and all state holds.
//
// Ports
//   clk       : clock, rising edge active
//   reset_n   : asynchronous, active-low reset
//   enable    : global advance qualifier
//   i_data    : input beat [0:DATA_W-1]
//   i_valid   : input beat valid
//   i_last    : final data beat of a frame (qualified by i_valid)
//   o_ready   : an input beat can be accepted this cycle
//   o_data    : output beat, either data or the CRC beat
//   o_valid   : o_data valid
//   o_last    : high on the CRC beat only
//   i_ready   : downstream accepts the output beat
//   o_crc     : CRC of the last completed frame
//   o_frames  : completed frame count, wraps at 16 bits
//   state_dbg : current FSM state (0 = DATA, 1 = CRC)
module crc_stream_enc #(
    parameter int                DATA_W = 8,
    parameter int                CRC_W  = 6,
    parameter logic [CRC_W-1:0]  POLY   = 6'h03,
    parameter logic [CRC_W-1:0]  INIT   = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [0:DATA_W-1] i_data,
    input  logic              i_valid,
    input  logic              i_last,
    output logic              o_ready,
    output logic [0:DATA_W-1] o_data,
    output logic              o_valid,
    output logic              o_last,
    input  logic              i_ready,
    output logic [0:CRC_W-1]  o_crc,
    output logic [15:0]       o_frames,
    output logic              state_dbg
);

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_CRC  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [0:CRC_W-1]  crc_q;
    logic [0:DATA_W-1] crc_beat;
    logic              in_xfer;
    logic              out_xfer;

    // Fold every bit of one beat into the CRC, bit 0 first. The register
    // shifts toward bit 0 (its MSB) and the feedback is crc[0] ^ data bit.
    function automatic logic [0:CRC_W-1] crc_fold(
        input logic [0:CRC_W-1]  c_in,
        input logic [0:DATA_W-1] d
    );
        logic [0:CRC_W-1] c;
        logic             fb;
        c = c_in;
        for (int i = 0; i < DATA_W; i++) begin
            fb = c[0] ^ d[i];
            c  = {c[1:CRC_W-1], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
        end
        return c;
    endfunction

    // The ready term lets a new beat in when the output register is empty
    // or is being drained on the same edge.
    assign o_ready   = enable & (state == ST_DATA) & (~o_valid | i_ready);
    assign in_xfer   = enable & i_valid & o_ready;
    assign out_xfer  = enable & o_valid & i_ready;
    assign state_dbg = state;

    // CRC left-justified in the beat, remaining bits zero.
    always_comb begin
        crc_beat            = '0;
        crc_beat[0:CRC_W-1] = crc_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_DATA;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_DATA: if (in_xfer && i_last)  state_next = ST_CRC;
            ST_CRC:  if (out_xfer && o_last) state_next = ST_DATA;
            default: state_next = ST_DATA;
        endcase
    end

    // Datapath. crc_q already holds INIT at the start of every frame, so the
    // first beat folds from INIT without a separate start flag. In ST_CRC the
    // output register first drains the last data beat, then the CRC beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_crc    <= '0;
            o_frames <= '0;
            crc_q    <= INIT;
        end else begin
            case (state)
                ST_DATA: begin
                    if (in_xfer) begin
                        o_data  <= i_data;
                        o_valid <= 1'b1;
                        o_last  <= 1'b0;
                        crc_q   <= crc_fold(crc_q, i_data);
                    end else if (out_xfer) begin
                        o_valid <= 1'b0;
                    end
                end
                ST_CRC: begin
                    if (out_xfer) begin
                        if (o_last) begin
                            o_valid  <= 1'b0;
                            o_last   <= 1'b0;
                            o_crc    <= crc_q;
                            o_frames <= o_frames + 16'd1;
                            crc_q    <= INIT;
                        end else begin
                            o_data <= crc_beat;
                            o_last <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_stream_enc.sv
module tb_crc_stream_enc;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [0:7] i_data;
    logic       i_valid;
    logic       i_last;
    logic       o_ready;
    logic [0:7] o_data;
    logic       o_valid;
    logic       o_last;
    logic       i_ready;
    logic [0:5] o_crc;
    logic [15:0] o_frames;
    logic       state_dbg;

    int checks;
    int failures;

    crc_stream_enc dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .i_last    (i_last),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_last    (o_last),
        .i_ready   (i_ready),
        .o_crc     (o_crc),
        .o_frames  (o_frames),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge, then settle 1 time unit before driving or sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // single-beat frame with i_ready high: data beat, CRC beat, frame done
    task automatic run_single(input string tag, input logic [7:0] d, input logic [7:0] exp_beat,
                              input logic [5:0] exp_crc, input logic [15:0] exp_frames);
        i_data  = d;
        i_valid = 1'b1;
        i_last  = 1'b1;
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
        chk({tag, "_data"},      o_data,  d);
        chk({tag, "_dvalid"},    o_valid, 1);
        chk({tag, "_dlast"},     o_last,  0);
        chk({tag, "_state_crc"}, state_dbg, 1);
        chk({tag, "_ready_lo"},  o_ready, 0);
        tick();
        chk({tag, "_beat"},      o_data,  exp_beat);
        chk({tag, "_blast"},     o_last,  1);
        chk({tag, "_bvalid"},    o_valid, 1);
        tick();
        chk({tag, "_idle"},      o_valid, 0);
        chk({tag, "_crc"},       o_crc,   exp_crc);
        chk({tag, "_frames"},    o_frames, exp_frames);
        chk({tag, "_ready_hi"},  o_ready, 1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        enable   = 1'b1;
        i_data   = '0;
        i_valid  = 1'b0;
        i_last   = 1'b0;
        i_ready  = 1'b1;

        // reset state
        #2;
        chk("rst_valid",  o_valid,  0);
        chk("rst_last",   o_last,   0);
        chk("rst_data",   o_data,   0);
        chk("rst_crc",    o_crc,    0);
        chk("rst_frames", o_frames, 0);
        chk("rst_state",  state_dbg, 0);
        chk("rst_ready",  o_ready,  1);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // single-beat frames
        run_single("f01", 8'h01, 8'h0C, 6'h03, 16'd1);
        run_single("f80", 8'h80, 8'h28, 6'h0A, 16'd2);
        run_single("f00", 8'h00, 8'h00, 6'h00, 16'd3);

        // two-beat frame; next frame's beat offered early is taken at N+2
        i_data = 8'h01; i_valid = 1'b1; i_last = 1'b0;
        tick();                                  // edge 1: accept beat 0
        chk("two_b0_data",  o_data,  8'h01);
        chk("two_b0_ready", o_ready, 1);
        chk("two_b0_state", state_dbg, 0);
        i_data = 8'h00; i_last = 1'b1;
        tick();                                  // edge 2: accept last
        chk("two_b1_data",  o_data,  8'h00);
        chk("two_b1_ready", o_ready, 0);
        i_data = 8'h01; i_last = 1'b1;           // next frame held waiting
        tick();                                  // edge 3: CRC beat loads
        chk("two_beat",     o_data,  8'h50);
        chk("two_blast",    o_last,  1);
        chk("two_wait_rdy", o_ready, 0);
        tick();                                  // edge 4: CRC beat leaves
        chk("two_crc",      o_crc,   6'h14);
        chk("two_frames",   o_frames, 16'd4);
        chk("two_idle",     o_valid, 0);
        chk("two_next_rdy", o_ready, 1);
        tick();                                  // edge 5: next first beat
        i_valid = 1'b0; i_last = 1'b0;
        chk("per_data",  o_data,  8'h01);
        chk("per_valid", o_valid, 1);
        chk("per_last",  o_last,  0);
        tick();
        chk("per_beat",  o_data,  8'h0C);
        tick();
        chk("per_crc",    o_crc,    6'h03);
        chk("per_frames", o_frames, 16'd5);

        // i_ready low while the CRC beat is presented
        i_data = 8'h80; i_valid = 1'b1; i_last = 1'b1;
        tick();
        i_valid = 1'b0; i_last = 1'b0;
        tick();
        chk("bp_beat", o_data, 8'h28);
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_data",   o_data,   8'h28);
            chk("bp_hold_valid",  o_valid,  1);
            chk("bp_hold_last",   o_last,   1);
            chk("bp_hold_ready",  o_ready,  0);
            chk("bp_hold_frames", o_frames, 16'd5);
        end
        i_ready = 1'b1;
        tick();
        chk("bp_frames", o_frames, 16'd6);
        chk("bp_crc",    o_crc,    6'h0A);
        chk("bp_idle",   o_valid,  0);

        // enable low between the beats of {01, 00}; second beat offered
        // throughout the window and must only be taken once enable returns
        i_data = 8'h01; i_valid = 1'b1; i_last = 1'b0;
        tick();
        i_data = 8'h00; i_last = 1'b1;
        enable = 1'b0;
        #1;
        chk("en_ready_lo", o_ready, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("en_hold_data",  o_data,    8'h01);
            chk("en_hold_valid", o_valid,   1);
            chk("en_hold_state", state_dbg, 0);
            chk("en_hold_ready", o_ready,   0);
        end
        enable = 1'b1;
        tick();
        i_valid = 1'b0; i_last = 1'b0;
        chk("en_b1_data",  o_data,    8'h00);
        chk("en_b1_state", state_dbg, 1);
        tick();
        chk("en_beat", o_data, 8'h50);
        tick();
        chk("en_crc",    o_crc,    6'h14);
        chk("en_frames", o_frames, 16'd7);

        // reset mid-frame after the first beat of a two-beat frame
        i_data = 8'h01; i_valid = 1'b1; i_last = 1'b0;
        tick();
        i_valid = 1'b0;
        chk("mr_pre_valid", o_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mr_valid",  o_valid,  0);
        chk("mr_data",   o_data,   0);
        chk("mr_last",   o_last,   0);
        chk("mr_crc",    o_crc,    0);
        chk("mr_frames", o_frames, 0);
        chk("mr_state",  state_dbg, 0);
        tick();
        reset_n = 1'b1;
        tick();
        run_single("mr_f01", 8'h01, 8'h0C, 6'h03, 16'd1);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
